// File: rtl/ysyx_22040237_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_wb_arbiter
//
// Write-back arbiter and register busy scoreboard for the 64-bit multi-cycle
// core. The EXU and the LSU share the single register-file write port; the
// port is granted round-robin and driven from registered outputs. A 32-entry
// busy scoreboard stalls issue on RAW/WAW hazards against in-flight writes.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid / iss_ready     issue handshake (ready is combinational)
//   iss_rd_en, iss_rd         destination register of the issuing instruction
//   iss_rs{1,2}_en, iss_rs*   source operands of the issuing instruction
//   exu_wb_* / lsu_wb_*       result handshakes (ready is combinational)
//   rf_wr_en/addr/data        registered register-file write port
//   busy                      scoreboard, bit i = write to xi outstanding
//   idle                      no outstanding writes and write port quiet
// ---------------------------------------------------------------------------
module ysyx_22040237_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic            iss_rd_en,
  input  logic [4:0]      iss_rd,
  input  logic            iss_rs1_en,
  input  logic            iss_rs2_en,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            exu_wb_valid,
  output logic            exu_wb_ready,
  input  logic [4:0]      exu_wb_rd,
  input  logic [XLEN-1:0] exu_wb_data,
  input  logic            lsu_wb_valid,
  output logic            lsu_wb_ready,
  input  logic [4:0]      lsu_wb_rd,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic [31:0]     busy,
  output logic            idle
);

  // Requester encoding recorded in r_last_grant.
  localparam logic GNT_EXU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // The counter saturates at 31 so it can never wrap.
  localparam logic [CNT_W-1:0] PEND_MAX  = CNT_W'(5'd31);
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};

  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_pend_cnt;
  logic             r_last_grant;
  logic             r_wr_en;
  logic [4:0]       r_wr_addr;
  logic [XLEN-1:0]  r_wr_data;

  logic             w_hazard;
  logic             w_set;
  logic             w_clr;
  logic [31:0]      w_set_mask;
  logic [31:0]      w_clr_mask;
  logic [31:0]      w_busy_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_gnt_exu;
  logic             w_gnt_lsu;
  logic [4:0]       w_gnt_rd;
  logic [XLEN-1:0]  w_gnt_data;

  // Issue hazard check and issue-side scoreboard set request.
  always_comb begin
    w_hazard  = (iss_rs1_en & r_busy[iss_rs1]) |
                (iss_rs2_en & r_busy[iss_rs2]) |
                (iss_rd_en  & r_busy[iss_rd]);
    iss_ready = ~rst & ~w_hazard & (r_pend_cnt != PEND_MAX);
    w_set     = iss_valid & iss_ready & iss_rd_en & (iss_rd != 5'd0);
  end

  // Busy bits clear on the same edge the RF latches the in-flight write;
  // set is applied after clear so a same-index set wins.
  always_comb begin
    w_clr      = r_wr_en & (r_wr_addr != 5'd0);
    w_set_mask = w_set ? (32'd1 << iss_rd) : 32'd0;
    w_clr_mask = w_clr ? (32'd1 << r_wr_addr) : 32'd0;
    w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  // Outstanding-write counter next value.
  always_comb begin
    case ({w_set, w_clr})
      2'b10:   w_pend_nxt = r_pend_cnt + PEND_ONE;
      2'b01:   w_pend_nxt = r_pend_cnt - PEND_ONE;
      default: w_pend_nxt = r_pend_cnt;
    endcase
  end

  // Round-robin grant: on a tie, the requester not granted last time wins.
  always_comb begin
    w_gnt_exu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (rst) begin
      w_gnt_exu = 1'b0;
      w_gnt_lsu = 1'b0;
    end else if (exu_wb_valid && lsu_wb_valid) begin
      if (r_last_grant == GNT_LSU) begin
        w_gnt_exu = 1'b1;
      end else begin
        w_gnt_lsu = 1'b1;
      end
    end else begin
      w_gnt_exu = exu_wb_valid;
      w_gnt_lsu = lsu_wb_valid;
    end
  end

  // Select the granted result for the write-port register.
  always_comb begin
    if (w_gnt_lsu) begin
      w_gnt_rd   = lsu_wb_rd;
      w_gnt_data = lsu_wb_data;
    end else begin
      w_gnt_rd   = exu_wb_rd;
      w_gnt_data = exu_wb_data;
    end
  end

  // Scoreboard, counter, grant history and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= 32'd0;
      r_pend_cnt   <= PEND_ZERO;
      r_last_grant <= GNT_LSU;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 5'd0;
      r_wr_data    <= {XLEN{1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pend_nxt;
      if (w_gnt_exu || w_gnt_lsu) begin
        r_last_grant <= w_gnt_lsu ? GNT_LSU : GNT_EXU;
        // An x0 result still completes its handshake but never writes.
        r_wr_en      <= (w_gnt_rd != 5'd0);
        r_wr_addr    <= w_gnt_rd;
        r_wr_data    <= w_gnt_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign exu_wb_ready = w_gnt_exu;
  assign lsu_wb_ready = w_gnt_lsu;
  assign rf_wr_en     = r_wr_en;
  assign rf_wr_addr   = r_wr_addr;
  assign rf_wr_data   = r_wr_data;
  assign busy         = r_busy;
  assign idle         = (r_pend_cnt == PEND_ZERO) & ~r_wr_en;

endmodule

// File: tb/tb_ysyx_22040237_wb_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_22040237_wb_arbiter. Stimulus is issued per cycle; the
// reference model predicts readies, busy and idle, and pushes every expected
// register-file write into a queue that an independent monitor drains.
// ---------------------------------------------------------------------------
module tb_ysyx_22040237_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            iss_valid, iss_ready, iss_rd_en, iss_rs1_en, iss_rs2_en;
  logic [4:0]      iss_rd, iss_rs1, iss_rs2;
  logic            exu_wb_valid, exu_wb_ready;
  logic [4:0]      exu_wb_rd;
  logic [XLEN-1:0] exu_wb_data;
  logic            lsu_wb_valid, lsu_wb_ready;
  logic [4:0]      lsu_wb_rd;
  logic [XLEN-1:0] lsu_wb_data;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [31:0]     busy;
  logic            idle;

  ysyx_22040237_wb_arbiter #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
    .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready), .exu_wb_rd(exu_wb_rd),
    .exu_wb_data(exu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_rd(lsu_wb_rd),
    .lsu_wb_data(lsu_wb_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { logic [4:0] rd; logic [63:0] data; } req_t;
  typedef struct { logic [4:0] rd; logic [63:0] data; int at; } wr_t;

  wr_t         exp_q[$];
  req_t        exu_q[$];
  req_t        lsu_q[$];
  int          pool[$];      // issued destinations not yet handed to a requester
  logic [31:0] m_busy;       // registers with a write outstanding
  bit          m_last_lsu;   // last grant went to the LSU
  int          m_inflight;   // register being written this cycle (0 = none)
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_iss(input logic v, input logic rd_en, input int rd,
                         input logic r1_en, input int r1, input logic r2_en, input int r2);
    iss_valid  = v;
    iss_rd_en  = rd_en;
    iss_rd     = 5'(rd);
    iss_rs1_en = r1_en;
    iss_rs1    = 5'(r1);
    iss_rs2_en = r2_en;
    iss_rs2    = 5'(r2);
  endtask

  // Requesters present the head of their queue and hold it until granted.
  task automatic drive_wb();
    exu_wb_valid = (exu_q.size() > 0);
    if (exu_q.size() > 0) begin
      exu_wb_rd   = exu_q[0].rd;
      exu_wb_data = exu_q[0].data;
    end
    lsu_wb_valid = (lsu_q.size() > 0);
    if (lsu_q.size() > 0) begin
      lsu_wb_rd   = lsu_q[0].rd;
      lsu_wb_data = lsu_q[0].data;
    end
  endtask

  // One clock: check combinational outputs against the model, advance it.
  task automatic cycle();
    logic exp_iss, haz, ge, gl;
    int   cnt;
    wr_t  w;
    drive_wb();
    @(negedge clk);
    haz = (iss_rs1_en && m_busy[iss_rs1]) || (iss_rs2_en && m_busy[iss_rs2]) ||
          (iss_rd_en && m_busy[iss_rd]);
    cnt = $countones(m_busy);
    exp_iss = !rst && !haz && (cnt != 31);
    ge = !rst && exu_wb_valid && (!lsu_wb_valid || m_last_lsu);
    gl = !rst && lsu_wb_valid && (!exu_wb_valid || !m_last_lsu);
    check("iss_ready", iss_ready, exp_iss);
    check("exu_wb_ready", exu_wb_ready, ge);
    check("lsu_wb_ready", lsu_wb_ready, gl);
    check("busy", busy, m_busy);
    check("idle", idle, (cnt == 0) && (m_inflight == 0));
    if (m_inflight != 0) m_busy[m_inflight] = 1'b0;
    if (iss_valid && exp_iss && iss_rd_en && iss_rd != 5'd0) begin
      m_busy[iss_rd] = 1'b1;
      pool.push_back(int'(iss_rd));
    end
    m_inflight = 0;
    if (ge) begin
      m_last_lsu = 1'b0;
      if (exu_q[0].rd != 5'd0) begin
        w.rd = exu_q[0].rd; w.data = exu_q[0].data; w.at = edge_cnt + 1;
        exp_q.push_back(w);
        m_inflight = int'(exu_q[0].rd);
      end
      void'(exu_q.pop_front());
    end
    if (gl) begin
      m_last_lsu = 1'b1;
      if (lsu_q[0].rd != 5'd0) begin
        w.rd = lsu_q[0].rd; w.data = lsu_q[0].data; w.at = edge_cnt + 1;
        exp_q.push_back(w);
        m_inflight = int'(lsu_q[0].rd);
      end
      void'(lsu_q.pop_front());
    end
    if (rst) begin
      m_busy = 32'd0;
      m_last_lsu = 1'b1;
      m_inflight = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic take_from_pool(input int rd, input bit to_lsu);
    req_t r;
    for (int i = 0; i < pool.size(); i++) begin
      if (pool[i] == rd) begin
        pool.delete(i);
        break;
      end
    end
    r.rd = 5'(rd);
    r.data = {$urandom, $urandom};
    if (to_lsu) lsu_q.push_back(r);
    else        exu_q.push_back(r);
  endtask

  // Hand every outstanding destination back to a requester and wait it out.
  task automatic drain(input string tag);
    int guard = 0;
    bit side = 1'b0;
    while ((pool.size() > 0 || exu_q.size() > 0 || lsu_q.size() > 0 || exp_q.size() > 0)
           && guard < 400) begin
      if (pool.size() > 0) begin
        take_from_pool(pool[0], side);
        side = ~side;
      end
      cycle();
      guard++;
    end
    check({tag, "_drain_timeout"}, (guard < 400), 1'b1);
    cycle();
    cycle();
  endtask

  // Monitor: every RF write must match the oldest expected one, on time.
  always @(negedge clk) begin
    wr_t e;
    if (rf_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write (t=%0t)",
                 rf_wr_addr, rf_wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", rf_wr_addr, e.rd);
        check("wr_data", rf_wr_data, e.data);
        check("wr_cycle", edge_cnt, e.at);
      end
    end
  end

  initial begin
    req_t r;
    rst = 1'b1;
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    exu_wb_valid = 1'b0; exu_wb_rd = 5'd0; exu_wb_data = 64'd0;
    lsu_wb_valid = 1'b0; lsu_wb_rd = 5'd0; lsu_wb_data = 64'd0;
    m_busy = 32'd0; m_last_lsu = 1'b1; m_inflight = 0;

    // Reset with both requesters valid (x0 results), then first tie -> EXU.
    r.rd = 5'd0; r.data = 64'h1111; exu_q.push_back(r);
    r.rd = 5'd0; r.data = 64'h2222; lsu_q.push_back(r);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_wr_addr", rf_wr_addr, 5'd0);
    check("rst_wr_data", rf_wr_data, 64'd0);
    rst = 1'b0;
    cycle();
    cycle();

    // RAW stall on x5 and release after the write edge.
    set_iss(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0);
    cycle();
    set_iss(1'b1, 1'b0, 0, 1'b1, 5, 1'b0, 0);
    take_from_pool(5, 1'b0);
    exu_q[0].data = 64'hDEAD;
    cycle();
    cycle();
    cycle();
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    cycle();

    // Round-robin under continuous contention.
    set_iss(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0); cycle();
    set_iss(1'b1, 1'b1, 4, 1'b0, 0, 1'b0, 0); cycle();
    set_iss(1'b1, 1'b1, 8, 1'b0, 0, 1'b0, 0); cycle();
    set_iss(1'b1, 1'b1, 9, 1'b0, 0, 1'b0, 0); cycle();
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    take_from_pool(3, 1'b0); take_from_pool(8, 1'b0);
    take_from_pool(4, 1'b1); take_from_pool(9, 1'b1);
    drain("rr");

    // x0 destination: no busy bit, handshake still consumed, no write.
    set_iss(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    cycle();
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    r.rd = 5'd0; r.data = 64'h0BAD; lsu_q.push_back(r);
    cycle();
    cycle();

    // Counter limit: 31 outstanding writes block issue until one retires.
    for (int i = 1; i < 32; i++) begin
      set_iss(1'b1, 1'b1, i, 1'b0, 0, 1'b0, 0);
      cycle();
    end
    set_iss(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    cycle();
    take_from_pool(7, 1'b0);
    cycle();
    cycle();
    cycle();
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drain("limit");

    // Reset mid-flight with one write in the output register.
    for (int i = 10; i < 14; i++) begin
      set_iss(1'b1, 1'b1, i, 1'b0, 0, 1'b0, 0);
      cycle();
    end
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    take_from_pool(13, 1'b0);
    cycle();
    rst = 1'b1;
    pool.delete();
    cycle();
    check("midrst_wr_en", rf_wr_en, 1'b0);
    check("midrst_busy", busy, 32'd0);
    check("midrst_idle", idle, 1'b1);
    cycle();
    rst = 1'b0;
    cycle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      int k;
      iss_valid  = 1'($urandom_range(0, 1));
      iss_rd_en  = 1'($urandom_range(0, 3) != 0);
      iss_rd     = 5'($urandom_range(0, 31));
      iss_rs1_en = 1'($urandom_range(0, 1));
      iss_rs1    = 5'($urandom_range(0, 31));
      iss_rs2_en = 1'($urandom_range(0, 1));
      iss_rs2    = 5'($urandom_range(0, 31));
      if (pool.size() > 0 && $urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, pool.size() - 1);
        take_from_pool(pool[k], 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 15) == 0) begin
        r.rd = 5'd0;
        r.data = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) exu_q.push_back(r);
        else lsu_q.push_back(r);
      end
      cycle();
    end
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drain("rand");

    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_idle", idle, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
